sram_masked_init: RTL and testbench



---
 rtl/sram_masked_init.sv | 170 +++++++++++++++++
 tb/tb_sram_masked_init.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_masked_init.sv
// sram_masked_init
// Single-port synchronous SRAM model with a per-lane write mask, a built-in
// zero-fill sequencer that runs after every reset, and an optional output
// pipeline register.
//
// Parameters:
//   DATA_WIDTH  word width, a multiple of MASK_GRAN
//   ADDR_WIDTH  address width, DEPTH = 1 << ADDR_WIDTH
//   MASK_GRAN   bits per mask lane, LANES = DATA_WIDTH / MASK_GRAN
//   OUT_REG     1 adds one register stage on dout/rvalid/parity_err
//
// Optional feature macro:
//   SRAM_PARITY_EN  store one even-parity bit per lane and flag mismatches on
//                   read; when undefined parity_err is tied low
//
// Ports:
//   clk         clock, everything on the rising edge
//   rst         synchronous active-high reset, restarts the zero-fill
//   ce          request valid
//   we          1 = write, 0 = read
//   wmask       per-lane write enable, bit i covers din[i*MASK_GRAN +: MASK_GRAN]
//   addr        word address
//   din         write data
//   dout        read data, holds the last read value
//   rvalid      one-cycle pulse aligned with new dout
//   ready       high once the zero-fill is done and requests are accepted
//   parity_err  read parity mismatch, aligned with rvalid
module sram_masked_init #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int MASK_GRAN  = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           we,
  input  logic [DATA_WIDTH/MASK_GRAN-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           rvalid,
  output logic                           ready,
  output logic                           parity_err
);

  localparam int LANES = DATA_WIDTH / MASK_GRAN;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  acc_rd, acc_wr;
  logic                  rd_perr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter wraps back to 0 on the last fill write, so it is already
  // cleared for the next reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (&cnt) state_nxt = RUN;
    end
  end

  assign ready  = (state == RUN);
  assign acc_rd = ready & ce & ~we;
  assign acc_wr = ready & ce & we;

  // The array itself is never reset; the fill sequencer gives it known contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (acc_wr) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) mem[addr][i*MASK_GRAN +: MASK_GRAN] <= din[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] lane_err;

  // Parity bits follow their lane's mask, so untouched lanes keep their check bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        par_mem[cnt] <= '0;
      end else if (acc_wr) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) par_mem[addr][i] <= ^din[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_comb begin
    lane_err = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_err[i] = (^mem[addr][i*MASK_GRAN +: MASK_GRAN]) ^ par_mem[addr][i];
    end
  end

  assign rd_perr = |lane_err;
`else
  assign rd_perr = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] d1;
  logic                  v1, p1;

  // First read stage: dout holds between reads, parity_err only pulses with rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      v1 <= acc_rd;
      p1 <= acc_rd & rd_perr;
      if (acc_rd) d1 <= mem[addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] d2;
      logic                  v2, p2;

      // Reset clears this stage too, so a read in flight is dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
          p2 <= 1'b0;
        end else begin
          v2 <= v1;
          p2 <= p1;
          if (v1) d2 <= d1;
        end
      end

      assign dout       = d2;
      assign rvalid     = v2;
      assign parity_err = p2;
    end else begin : g_noreg
      assign dout       = d1;
      assign rvalid     = v1;
      assign parity_err = p1;
    end
  endgenerate

endmodule

// File: tb/tb_sram_masked_init.sv
// tb_sram_masked_init
// Drives two instances (OUT_REG=0 and OUT_REG=1, ADDR_WIDTH=4) with the same
// stimulus. Reads push expected data plus the cycle it must appear in onto a
// per-instance queue; a negedge monitor pops and compares on rvalid and checks
// that dout holds otherwise.
module tb_sram_masked_init;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int LN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic [LN-1:0] wmask = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout0, dout1;
  logic          rvalid0, rvalid1, ready0, ready1, perr0, perr1;

  always #5 clk = ~clk;

  sram_masked_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(8), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout0), .rvalid(rvalid0), .ready(ready0), .parity_err(perr0)
  );

  sram_masked_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(8), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout1), .rvalid(rvalid1), .ready(ready1), .parity_err(perr1)
  );

  typedef struct {
    logic          ce;
    logic          we;
    logic [LN-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] held0 = '0;
  logic [DW-1:0] held1 = '0;
  int            cyc = 0;
  logic          rst_q = 1'b1;
  int            vectors = 0;
  int            miscompares = 0;

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  function automatic vec_t mkWr(input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [DW-1:0] d);
    vec_t v;
    v = '{1'b1, 1'b1, m, a, d, '0};
    return v;
  endfunction

  function automatic vec_t mkRd(input logic [AW-1:0] a, input logic [DW-1:0] x);
    vec_t v;
    v = '{1'b1, 1'b0, 8'hFF, a, 64'h5A5A_5A5A_5A5A_5A5A, x};
    return v;
  endfunction

  function automatic vec_t mkOff(input logic w, input logic [AW-1:0] a);
    vec_t v;
    v = '{1'b0, w, 8'hFF, a, 64'h0, '0};
    return v;
  endfunction

  task automatic monitorPort(input int p, input logic rv, input logic [DW-1:0] d, input logic pe);
    exp_t e;
    logic have;
    have = 1'b0;
    if (p == 0) begin
      if (q0.size() > 0 && (rv || q0[0].due <= cyc)) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && (rv || q1[0].due <= cyc)) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (rv) begin
      if (!have) begin
        checkBit($sformatf("port%0d unexpected rvalid @%0d", p, cyc), rv, 1'b0);
      end else begin
        checkOutput($sformatf("port%0d rvalid cycle", p), 64'(cyc), 64'(e.due));
        checkOutput($sformatf("port%0d dout @%0d", p, cyc), d, e.data);
        checkBit($sformatf("port%0d parity_err @%0d", p, cyc), pe, e.perr);
        if (p == 0) held0 = e.data; else held1 = e.data;
      end
    end else begin
      if (have) checkBit($sformatf("port%0d missing rvalid @%0d", p, cyc), rv, 1'b1);
      checkOutput($sformatf("port%0d dout hold @%0d", p, cyc), d, (p == 0) ? held0 : held1);
    end
  endtask

  // Reset discards everything in flight, so the expectations are flushed too.
  always @(negedge clk) begin
    if (rst_q) begin
      q0.delete();
      q1.delete();
      held0 = '0;
      held1 = '0;
    end else begin
      monitorPort(0, rvalid0, dout0, perr0);
      monitorPort(1, rvalid1, dout1, perr1);
    end
  end

  task automatic applyStimulus(input vec_t v, input logic perr_exp);
    exp_t e;
    @(negedge clk);
    ce    = v.ce;
    we    = v.we;
    wmask = v.wmask;
    addr  = v.addr;
    din   = v.din;
    if (v.ce && !v.we) begin
      e.data = v.exp;
      e.perr = perr_exp;
      e.due  = cyc + 1;
      q0.push_back(e);
      e.due  = cyc + 2;
      q1.push_back(e);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkBit("reset ready0", ready0, 1'b0);
    checkBit("reset ready1", ready1, 1'b0);
    checkBit("reset rvalid0", rvalid0, 1'b0);
    checkBit("reset rvalid1", rvalid1, 1'b0);
    checkOutput("reset dout0", dout0, '0);
    checkOutput("reset dout1", dout1, '0);
    checkBit("reset parity_err0", perr0, 1'b0);
    checkBit("reset parity_err1", perr1, 1'b0);
  endtask

  // Counts cycles with ready low, optionally throwing requests at the busy
  // memory; none may be accepted.
  task automatic waitInit(input bit poke);
    int low;
    low = 0;
    while (ready0 !== 1'b1 && low < 40) begin
      low++;
      if (poke) begin
        ce    = 1'b1;
        we    = low[0];
        wmask = '1;
        addr  = 4'd5;
        din   = 64'hABCD;
      end
      @(negedge clk);
    end
    ce = 1'b0;
    checkOutput("init ready-low cycles", 64'(low), 64'd16);
    checkBit("ready1 after init", ready1, 1'b1);
  endtask

  initial begin
    vec_t tbl [19];
    tbl[0]  = mkWr(4'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tbl[1]  = mkWr(4'd3, 8'h0F, 64'h1122_3344_5566_7788);
    tbl[2]  = mkRd(4'd3, 64'hFFFF_FFFF_5566_7788);
    tbl[3]  = mkWr(4'd9, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    tbl[4]  = mkRd(4'd9, 64'h0);
    tbl[5]  = mkWr(4'd0, 8'hFF, 64'h1010_1010_1010_1010);
    tbl[6]  = mkWr(4'd1, 8'hFF, 64'h2121_2121_2121_2121);
    tbl[7]  = mkWr(4'd2, 8'hFF, 64'h3232_3232_3232_3232);
    tbl[8]  = mkRd(4'd2, 64'h3232_3232_3232_3232);
    tbl[9]  = mkRd(4'd0, 64'h1010_1010_1010_1010);
    tbl[10] = mkRd(4'd1, 64'h2121_2121_2121_2121);
    tbl[11] = mkRd(4'd2, 64'h3232_3232_3232_3232);
    tbl[12] = mkOff(1'b1, 4'd3);
    tbl[13] = mkOff(1'b0, 4'd3);
    tbl[14] = mkRd(4'd3, 64'hFFFF_FFFF_5566_7788);
    tbl[15] = mkWr(4'd3, 8'hA0, 64'h0);
    tbl[16] = mkRd(4'd3, 64'h00FF_00FF_5566_7788);
    tbl[17] = mkWr(4'd4, 8'h3C, 64'h0123_4567_89AB_CDEF);
    tbl[18] = mkRd(4'd4, 64'h0000_4567_89AB_0000);

    $display("[TB] start");
    doReset();
    waitInit(1'b1);

    for (int a = 0; a < 16; a++) applyStimulus(mkRd(4'(a), 64'h0), 1'b0);
    for (int i = 0; i < 19; i++) applyStimulus(tbl[i], 1'b0);

    applyStimulus(mkRd(4'd3, 64'h00FF_00FF_5566_7788), 1'b0);
    doReset();
    waitInit(1'b0);
    applyStimulus(mkRd(4'd3, 64'h0), 1'b0);
    applyStimulus(mkRd(4'd0, 64'h0), 1'b0);
    applyStimulus(mkRd(4'd4, 64'h0), 1'b0);

`ifdef SRAM_PARITY_EN
    applyStimulus(mkWr(4'd7, 8'hFF, 64'h0123_4567_89AB_CDEF), 1'b0);
    applyStimulus(mkOff(1'b0, 4'd0), 1'b0);
    u_dut0.mem[7][17] = ~u_dut0.mem[7][17];
    u_dut1.mem[7][17] = ~u_dut1.mem[7][17];
    applyStimulus(mkRd(4'd7, 64'h0123_4567_89AB_CDEF ^ 64'h0000_0000_0002_0000), 1'b1);
    applyStimulus(mkRd(4'd3, 64'h0), 1'b0);
`endif

    for (int i = 0; i < 4; i++) applyStimulus(mkOff(1'b0, 4'd0), 1'b0);
    checkOutput("port0 queue drained", 64'(q0.size()), 64'd0);
    checkOutput("port1 queue drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exhausted, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
